// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//   Back end of the multiplier datapath: sums N_TERMS unsigned products into a
//   saturating ACC_W-bit accumulator and hands the sum (plus a sticky overflow
//   flag) to a consumer over a valid/ready handshake.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset (highest priority)
//   prod_in    in   P+K      unsigned product
//   prod_valid in   1        prod_in is valid
//   prod_ready out  1        a product can be accepted this cycle
//   clear      in   1        synchronous abort of the partial sum / pending result
//   acc_out    out  ACC_W    accumulated sum (qualified by acc_valid)
//   ovf        out  1        sticky saturation flag (qualified by acc_valid)
//   acc_valid  out  1        result available
//   acc_ready  in   1        consumer takes the result
//   term_cnt   out  CNT_W    products accepted into the current sum
// ---------------------------------------------------------------------------
module product_accumulator #(
  parameter int P       = 8,
  parameter int K       = 8,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 18,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [P+K-1:0]     prod_in,
  input  logic               prod_valid,
  output logic               prod_ready,
  input  logic               clear,
  output logic [ACC_W-1:0]   acc_out,
  output logic               ovf,
  output logic               acc_valid,
  input  logic               acc_ready,
  output logic [CNT_W-1:0]   term_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Saturating add. Bit ACC_W of the result is the overflow indication;
  // the low ACC_W bits are the (possibly saturated) sum.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [P+K-1:0]   prod);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + (ACC_W+1)'(prod);
    if (sum[ACC_W]) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = sum;
    end
  endfunction

  state_t            state_r;
  logic [ACC_W-1:0]  acc_r;
  logic              ovf_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              prod_ready_r;
  logic              acc_valid_r;

  logic              accept_s;
  logic              last_s;
  logic [ACC_W:0]    sum_s;

  // Handshake qualification and next-sum datapath.
  always_comb begin
    accept_s = 1'b0;
    last_s   = 1'b0;
    sum_s    = {(ACC_W+1){1'b0}};
    accept_s = prod_valid & prod_ready_r & ~clear;
    // The incoming product is the final term when N_TERMS-1 are already in.
    last_s   = (cnt_r == CNT_W'(N_TERMS - 1));
    sum_s    = sat_add(acc_r, prod_in);
  end

  // Control FSM with registered datapath and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      acc_r        <= {ACC_W{1'b0}};
      ovf_r        <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      prod_ready_r <= 1'b1;
      acc_valid_r  <= 1'b0;
    end else if (clear) begin
      // Abort wins over any handshake in the same cycle, including a result handoff.
      state_r      <= IDLE;
      acc_r        <= {ACC_W{1'b0}};
      ovf_r        <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      prod_ready_r <= 1'b1;
      acc_valid_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (accept_s) begin
            acc_r <= sum_s[ACC_W-1:0];
            ovf_r <= ovf_r | sum_s[ACC_W];
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (last_s) begin
              state_r      <= DONE;
              prod_ready_r <= 1'b0;
              acc_valid_r  <= 1'b1;
            end else begin
              state_r      <= ACCUM;
              prod_ready_r <= 1'b1;
              acc_valid_r  <= 1'b0;
            end
          end else begin
            state_r <= state_r;
          end
        end
        DONE: begin
          if (acc_ready) begin
            state_r      <= IDLE;
            acc_r        <= {ACC_W{1'b0}};
            ovf_r        <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            prod_ready_r <= 1'b1;
            acc_valid_r  <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r      <= IDLE;
          acc_r        <= {ACC_W{1'b0}};
          ovf_r        <= 1'b0;
          cnt_r        <= {CNT_W{1'b0}};
          prod_ready_r <= 1'b1;
          acc_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign prod_ready = prod_ready_r;
  assign acc_valid  = acc_valid_r;
  assign acc_out    = acc_r;
  assign ovf        = ovf_r;
  assign term_cnt   = cnt_r;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  localparam int ACC_W  = 18;
  localparam int N      = 4;
  localparam int CNT_W  = 3;
  localparam int ACC_W2 = 16;
  localparam int N2     = 2;
  localparam int CNT_W2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, clear;
  logic [15:0]       prod_in;
  logic              prod_valid, prod_ready, ovf, acc_valid, acc_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  term_cnt;

  logic [15:0]       p2_in;
  logic              p2_valid, p2_ready, ovf2, a2_valid, a2_ready;
  logic [ACC_W2-1:0] acc2;
  logic [CNT_W2-1:0] cnt2;

  product_accumulator dut (
    .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .clear(clear), .acc_out(acc_out), .ovf(ovf),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .term_cnt(term_cnt)
  );

  product_accumulator #(.P(8), .K(8), .N_TERMS(N2), .ACC_W(ACC_W2), .CNT_W(CNT_W2)) dut2 (
    .clk(clk), .rst(rst), .prod_in(p2_in), .prod_valid(p2_valid),
    .prod_ready(p2_ready), .clear(clear), .acc_out(acc2), .ovf(ovf2),
    .acc_valid(a2_valid), .acc_ready(a2_ready), .term_cnt(cnt2)
  );

  int checks = 0;
  int passed = 0;

  // Scoreboard of expected results, {ovf, acc}, pushed as the Nth product is sent.
  logic [ACC_W:0] exp_q[$];
  longint m_acc;
  bit     m_ovf;
  int     m_cnt;

  task automatic model_reset();
    m_acc = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one product for exactly one cycle and feed the reference model.
  task automatic send(input logic [15:0] v);
    logic [ACC_W:0] e;
    prod_in    = v;
    prod_valid = 1'b1;
    checks++;
    if (prod_ready !== 1'b1) $display("FAIL send_ready: prod_ready=%0b required 1", prod_ready);
    else passed++;
    step();
    prod_valid = 1'b0;
    m_acc = m_acc + longint'(v);
    if (m_acc > longint'((1 << ACC_W) - 1)) begin
      m_acc = longint'((1 << ACC_W) - 1);
      m_ovf = 1'b1;
    end
    m_cnt++;
    if (m_cnt == N) begin
      e = {m_ovf, m_acc[ACC_W-1:0]};
      exp_q.push_back(e);
      model_reset();
    end
  endtask

  // Wait (bounded) for a result, compare with the scoreboard, then hand it off.
  task automatic collect(input string name);
    logic [ACC_W:0] e;
    for (int i = 0; i < 20 && acc_valid !== 1'b1; i++) step();
    checks++;
    if (acc_valid !== 1'b1) begin
      $display("FAIL %s_timeout: acc_valid=%0b required 1", name, acc_valid);
      return;
    end else passed++;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s_queue: result seen with empty scoreboard size=%0d required 1", name, exp_q.size());
      return;
    end else passed++;
    e = exp_q.pop_front();
    checks++;
    if (acc_out !== e[ACC_W-1:0]) $display("FAIL %s_acc: acc_out=%0d required %0d", name, acc_out, e[ACC_W-1:0]);
    else passed++;
    checks++;
    if (ovf !== e[ACC_W]) $display("FAIL %s_ovf: ovf=%0b required %0b", name, ovf, e[ACC_W]);
    else passed++;
    checks++;
    if (term_cnt !== CNT_W'(N)) $display("FAIL %s_cnt: term_cnt=%0d required %0d", name, term_cnt, N);
    else passed++;
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    checks++;
    if (acc_valid !== 1'b0 || acc_out !== '0 || term_cnt !== '0 || prod_ready !== 1'b1)
      $display("FAIL %s_handoff: valid=%0b acc=%0d cnt=%0d ready=%0b required 0/0/0/1",
               name, acc_valid, acc_out, term_cnt, prod_ready);
    else passed++;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (acc_out !== '0 || ovf !== 1'b0 || term_cnt !== '0 || acc_valid !== 1'b0 || prod_ready !== 1'b1)
      $display("FAIL %s: acc=%0d ovf=%0b cnt=%0d valid=%0b ready=%0b required 0/0/0/0/1",
               name, acc_out, ovf, term_cnt, acc_valid, prod_ready);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check_idle("reset");
    checks++;
    if (acc2 !== '0 || a2_valid !== 1'b0 || p2_ready !== 1'b1)
      $display("FAIL reset2: acc=%0d valid=%0b ready=%0b required 0/0/1", acc2, a2_valid, p2_ready);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) send(16'd65025);
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 18'd260100)
      $display("FAIL b2b_latency: valid=%0b acc=%0d required 1/260100", acc_valid, acc_out);
    else passed++;
    collect("b2b");
  endtask

  task automatic test_overflow();
    p2_in = 16'd65025; p2_valid = 1'b1;
    step();
    p2_in = 16'd1000;
    step();
    p2_valid = 1'b0;
    checks++;
    if (a2_valid !== 1'b1 || acc2 !== 16'hFFFF || ovf2 !== 1'b1 || cnt2 !== 2'd2)
      $display("FAIL ovf_sat: valid=%0b acc=%0d ovf=%0b cnt=%0d required 1/65535/1/2",
               a2_valid, acc2, ovf2, cnt2);
    else passed++;
    a2_ready = 1'b1;
    step();
    a2_ready = 1'b0;
    checks++;
    if (a2_valid !== 1'b0 || acc2 !== '0 || ovf2 !== 1'b0 || cnt2 !== '0 || p2_ready !== 1'b1)
      $display("FAIL ovf_handoff: valid=%0b acc=%0d ovf=%0b cnt=%0d ready=%0b required 0/0/0/0/1",
               a2_valid, acc2, ovf2, cnt2, p2_ready);
    else passed++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) send(16'd5);
    prod_in    = 16'd99;
    prod_valid = 1'b1;
    acc_ready  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (prod_ready !== 1'b0 || acc_valid !== 1'b1 || acc_out !== 18'd20 || term_cnt !== 3'd4)
        $display("FAIL stall_c%0d: ready=%0b valid=%0b acc=%0d cnt=%0d required 0/1/20/4",
                 c, prod_ready, acc_valid, acc_out, term_cnt);
      else passed++;
      step();
    end
    prod_valid = 1'b0;
    collect("stall");
  endtask

  task automatic test_clear();
    send(16'd100);
    send(16'd100);
    clear = 1'b1; prod_valid = 1'b1; prod_in = 16'd7;
    step();
    clear = 1'b0; prod_valid = 1'b0;
    model_reset();
    check_idle("clear_accum");
    for (int i = 0; i < 4; i++) send(16'd1);
    checks++;
    if (acc_out !== 18'd4) $display("FAIL clear_sum: acc_out=%0d required 4", acc_out);
    else passed++;
    collect("clear");
    // Clear in DONE beats a simultaneous result handoff: the result is discarded.
    for (int i = 0; i < 4; i++) send(16'd3);
    clear = 1'b1; acc_ready = 1'b1;
    step();
    clear = 1'b0; acc_ready = 1'b0;
    void'(exp_q.pop_back());
    check_idle("clear_done");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) send(16'd10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check_idle("rst_mid");
    for (int i = 0; i < 4; i++) send(16'd10);
    checks++;
    if (acc_out !== 18'd40) $display("FAIL rst_sum: acc_out=%0d required 40", acc_out);
    else passed++;
    collect("rst_mid");
  endtask

  task automatic test_gaps();
    for (int v = 1; v <= 4; v++) begin
      send(16'(v));
      checks++;
      if (term_cnt !== CNT_W'(v)) $display("FAIL gap_cnt%0d: term_cnt=%0d required %0d", v, term_cnt, v);
      else passed++;
      prod_in = 16'd50;
      step();
      checks++;
      if (term_cnt !== CNT_W'(v)) $display("FAIL gap_hold%0d: term_cnt=%0d required %0d", v, term_cnt, v);
      else passed++;
    end
    checks++;
    if (acc_out !== 18'd10) $display("FAIL gap_sum: acc_out=%0d required 10", acc_out);
    else passed++;
    collect("gaps");
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; prod_in = '0; prod_valid = 1'b0; acc_ready = 1'b0;
    p2_in = '0; p2_valid = 1'b0; a2_ready = 1'b0;
    model_reset();
    step();
    step();
    test_reset();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_gaps();
    checks++;
    if (exp_q.size() != 0) $display("FAIL leftover: scoreboard size=%0d required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
